// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
//   Sums per-word population counts across a frame. A frame ends on the
//   in_last beat, or it is force-closed when it reaches MAX_WORDS beats. The
//   frame result is then held on the outputs until downstream accepts it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   a beat is present on the input
//   in_ready   the block accepts a beat this cycle (high only in ACCUM)
//   in_count   ones count of the current word (0..DATA_WIDTH)
//   in_last    current beat is the final beat of its frame
//   out_valid  frame result is held on the outputs
//   out_ready  downstream accepts the frame result
//   out_total  sum of in_count over the frame
//   out_words  number of beats in the frame (1..MAX_WORDS)
//   out_err    frame was force-closed at MAX_WORDS without in_last
module ones_frame_accumulator #(
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_WORDS  = 16,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1,
  localparam int SUM_WIDTH  = $clog2(DATA_WIDTH * MAX_WORDS + 1),
  localparam int WC_WIDTH   = $clog2(MAX_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CNT_WIDTH-1:0] in_count,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_WIDTH-1:0] out_total,
  output logic [WC_WIDTH-1:0]  out_words,
  output logic                 out_err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [SUM_WIDTH-1:0] acc, acc_nxt, sum_next, total_nxt;
  logic [WC_WIDTH-1:0]  wc, wc_nxt, wc_next, words_nxt;
  logic                 err_nxt, valid_nxt;
  logic                 accept, close;

  // Pure decode of the state flop: no path from out_ready into in_ready.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;

  // in_count is added unmodified; out-of-range counts are an upstream error.
  assign sum_next = acc + SUM_WIDTH'(in_count);
  assign wc_next  = wc + WC_WIDTH'(1);
  assign close    = in_last || (wc_next == WC_WIDTH'(MAX_WORDS));

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    wc_nxt    = wc;
    total_nxt = out_total;
    words_nxt = out_words;
    err_nxt   = out_err;
    valid_nxt = out_valid;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (close) begin
            total_nxt = sum_next;
            words_nxt = wc_next;
            // A last beat landing exactly on the limit is a legal end.
            err_nxt   = !in_last;
            valid_nxt = 1'b1;
            acc_nxt   = '0;
            wc_nxt    = '0;
            state_nxt = HOLD;
          end else begin
            acc_nxt = sum_next;
            wc_nxt  = wc_next;
          end
        end
      end
      HOLD: begin
        // Result fields are left untouched after the handshake.
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      wc        <= '0;
      out_total <= '0;
      out_words <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      wc        <= wc_nxt;
      out_total <= total_nxt;
      out_words <= words_nxt;
      out_err   <= err_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule
